// File: rtl/booth_mul_arbiter_pkg.sv
// Shared definitions for the booth multiplier arbiter: FSM encodings and default widths.
package booth_mul_arbiter_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared booth multiplier arbiter.
interface booth_mul_arbiter_if
  import booth_mul_arbiter_pkg::*;
  #(parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][W-1:0]  req_a;
  logic [NREQ-1:0][W-1:0]  req_b;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         rsp_valid;
  logic [2*W-1:0]          rsp_data;
  logic                    rsp_err;
  logic                    mul_start;
  logic [W-1:0]            mul_a;
  logic [W-1:0]            mul_b;
  logic                    mul_finish;
  logic [2*W-1:0]          mul_out;

  modport slave (
    input  req, req_a, req_b, mul_finish, mul_out,
    output gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b
  );

  modport master (
    output req, req_a, req_b, mul_finish, mul_out,
    input  gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/booth_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after rr_last, wrapping modulo NREQ.
module rr_pick
  import booth_mul_arbiter_pkg::*;
  #(parameter int NREQ = DEF_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1)
  (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
  );

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_last) + k) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential booth multiplier between NREQ requesters (round-robin, one job in flight).
// Optional watchdog abort enabled with BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
  #(parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
`ifdef BOOTH_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT = DEF_TIMEOUT
`endif
  )
  (
    input  logic                clk,
    input  logic                rst_n,
    booth_mul_arbiter_if.slave  bus
  );

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [2:0]      state_q, state_d;
  logic [W-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [IW-1:0]   owner_q, owner_d, rr_last_q, rr_last_d;
  logic [2*W-1:0]  rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            timeout;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .rr_last (rr_last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: if (|bus.req) begin
        mul_a_d = bus.req_a[win_idx];
        mul_b_d = bus.req_b[win_idx];
        owner_d = win_idx;
        state_d = S_START;
      end
      S_START: state_d = S_ARM;
      // finish may still be high from the previous job; skip it for one cycle
      S_ARM:   state_d = S_BUSY;
      S_BUSY: if (bus.mul_finish) begin
        rsp_data_d = bus.mul_out;
        state_d    = S_RESP;
      end else if (timeout) begin
        rsp_data_d = '0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        rr_last_d = owner_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      owner_q    <= '0;
      rr_last_q  <= IW'(NREQ - 1);
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;

  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == S_START)     cnt_d = '0;
    else if (state_q == S_BUSY) cnt_d = cnt_q + 1'b1;
    if (state_q == S_BUSY && bus.mul_finish) rsp_err_d = 1'b0;
    else if (state_q == S_BUSY && timeout)   rsp_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // gnt is combinational in IDLE; gating with rst_n keeps it low during reset
  assign bus.gnt       = (state_q == S_IDLE && rst_n) ? win : '0;
  assign bus.rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mul_start = (state_q == S_START);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: behavioural multiplier, cycle-level reference model, directed + random traffic.
module tb_booth_mul_arbiter;
  import booth_mul_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

  booth_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural sequential multiplier: finish stays high until the cycle after the next start is seen.
  logic               mf     = 1'b0;
  logic [2*W-1:0]     mo     = '0;
  logic signed [15:0] m_prod = '0;
  int                 m_cnt  = 0;
  int                 next_d = 1;
  assign bus.mul_finish = mf;
  assign bus.mul_out    = mo;

  always @(posedge clk) begin
    if (bus.mul_start) begin
      m_cnt  <= next_d;
      m_prod <= $signed(bus.mul_a) * $signed(bus.mul_b);
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
      mf    <= 1'b0;
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      mf    <= 1'b1;
      mo    <= m_prod;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int              cyc = 0, rr_m = NREQ - 1, own_m = 0, gnt_cyc = -100, rsp_cyc = -100, force_d = 0;
  bit              idle_m = 1'b1, resp_done = 1'b0, hang = 1'b0;
  logic [W-1:0]    ea = '0, eb = '0;
  logic [2*W-1:0]  eprod = '0;
  logic            eerr = 1'b0;
  logic [NREQ-1:0] g_seen = '0, hold = '0;
  int              rsp_own[$];
  logic [2*W-1:0]  rsp_dat[$];

  task automatic monitor();
    logic [NREQ-1:0] eg, erv;
    int w;
    g_seen = bus.gnt;
    if (!rst_n) begin
      idle_m = 1'b1; resp_done = 1'b0; rr_m = NREQ - 1;
      return;
    end
    cyc++;
    if (resp_done) begin idle_m = 1'b1; resp_done = 1'b0; end
    eg = '0; w = -1;
    if (idle_m)
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && bus.req[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", bus.gnt, eg);
    if (w >= 0) begin
      idle_m  = 1'b0; own_m = w; gnt_cyc = cyc;
      ea      = bus.req_a[w]; eb = bus.req_b[w];
      eprod   = $signed(bus.req_a[w]) * $signed(bus.req_b[w]);
      eerr    = 1'b0;
      next_d  = (force_d > 0) ? force_d : int'($urandom_range(6, 1));
      rsp_cyc = cyc + 3 + next_d;
      if (hang) begin
        next_d = 1000; eprod = '0; eerr = 1'b1; rsp_cyc = cyc + 3 + DEF_TIMEOUT;
      end
    end
    chk("mul_start", bus.mul_start, !idle_m && cyc == gnt_cyc + 1);
    if (!idle_m && cyc > gnt_cyc) begin
      chk("mul_a", bus.mul_a, ea);
      chk("mul_b", bus.mul_b, eb);
    end
    erv = '0;
    if (!idle_m && cyc == rsp_cyc) erv[own_m] = 1'b1;
    chk("rsp_valid", bus.rsp_valid, erv);
    if (erv != '0) begin
      chk("rsp_data", bus.rsp_data, eprod);
      chk("rsp_err", bus.rsp_err, eerr);
      rsp_own.push_back(own_m);
      rsp_dat.push_back(bus.rsp_data);
      rr_m = own_m; resp_done = 1'b1;
    end
  endtask

  // One clock: check at negedge, then drop granted requests that are not held.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (g_seen[i] && !hold[i]) bus.req[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req[i] = 1'b1; bus.req_a[i] = a; bus.req_b[i] = b;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int k = 0; k < budget && rsp_own.size() < n; k++) step();
    chk("rsp_count", rsp_own.size(), n);
  endtask

  task automatic expect_log(input string tag, input int idx, input int own, input logic [2*W-1:0] dat);
    if (idx < rsp_own.size()) begin
      chk({tag, "_own"}, rsp_own[idx], own);
      chk({tag, "_data"}, rsp_dat[idx], dat);
    end else chk({tag, "_missing"}, rsp_own.size(), idx + 1);
  endtask

  task automatic do_reset();
    bus.req = '0; hold = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    int b, n1;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;

    // 1: single request
    do_reset();
    b = rsp_own.size();
    set_req(0, 8'd7, 8'd5);
    wait_rsp(b + 1, 40);
    expect_log("t1", b, 0, 16'd35);

    // 2: all four requesting right after reset
    do_reset();
    b = rsp_own.size();
    set_req(0, 8'd9, 8'd9);
    set_req(1, 8'hFA, 8'd3);
    set_req(2, 8'd2, 8'hFC);
    set_req(3, 8'hF8, 8'hF8);
    wait_rsp(b + 4, 100);
    expect_log("t2a", b,     0, 16'd81);
    expect_log("t2b", b + 1, 1, 16'hFFEE);
    expect_log("t2c", b + 2, 2, 16'hFFF8);
    expect_log("t2d", b + 3, 3, 16'd64);

    // 3: two requesters held continuously alternate
    b = rsp_own.size();
    hold = 4'b0101;
    set_req(0, 8'd3, 8'd4);
    set_req(2, 8'hFE, 8'd5);
    wait_rsp(b + 4, 100);
    bus.req = '0; hold = '0;
    for (int k = 0; k < 20; k++) step();
    expect_log("t3a", b,     0, 16'd12);
    expect_log("t3b", b + 1, 2, 16'hFFF6);
    expect_log("t3c", b + 2, 0, 16'd12);
    expect_log("t3d", b + 3, 2, 16'hFFF6);

    // 4: request withdrawn while another job is in flight
    b = rsp_own.size();
    set_req(0, 8'd12, 8'hFD);
    step(); step();
    set_req(1, 8'd4, 8'd4);
    step();
    bus.req[1] = 1'b0;
    wait_rsp(b + 1, 40);
    for (int k = 0; k < 10; k++) step();
    chk("t4_count", rsp_own.size(), b + 1);
    n1 = 0;
    for (int k = b; k < rsp_own.size(); k++) if (rsp_own[k] == 1) n1++;
    chk("t4_no_rsp1", n1, 0);

    // 5: reset in BUSY, then a job with a stale finish flag
    force_d = 6;
    set_req(1, 8'd100, 8'd3);
    step(); step(); step(); step();
    do_reset();
    force_d = 0;
    for (int k = 0; k < 20 && !mf; k++) step();
    chk("t5_stale_finish", mf, 1);
    b = rsp_own.size();
    set_req(3, 8'hFF, 8'hFF);
    wait_rsp(b + 1, 40);
    expect_log("t5", b, 3, 16'd1);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // 6: multiplier never finishes -> watchdog abort
    b = rsp_own.size();
    hang = 1'b1;
    set_req(2, 8'd5, 8'd5);
    wait_rsp(b + 1, DEF_TIMEOUT + 20);
    hang = 1'b0;
    expect_log("t6", b, 2, 16'd0);
`endif

    // Random traffic: raise, withdraw, hold-through-grant with new operands
    hold = '1;
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (g_seen[i]) begin
          if ($urandom % 2 == 0) bus.req[i] = 1'b0;
          else begin bus.req_a[i] = W'($urandom); bus.req_b[i] = W'($urandom); end
        end else if (!bus.req[i] && $urandom % 4 == 0) begin
          set_req(i, W'($urandom), W'($urandom));
        end else if (bus.req[i] && $urandom % 32 == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0; hold = '0;
    for (int k = 0; k < 20; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
